// File: rtl/noc_flit_eject_axis_if.sv
// Ejection-port bundle: router send/credit link on one side, AXI-Stream beats on the other.
// The slave modport is the ejection block's view; the master modport is the environment's.
interface noc_flit_eject_axis_if #(
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 1
);
  localparam int FLIT_WIDTH = TDATA_WIDTH / SERIALIZATION_FACTOR;
  localparam int DEST_WIDTH = TDEST_WIDTH + TID_WIDTH;

  logic [FLIT_WIDTH-1:0]  data_in;
  logic [DEST_WIDTH-1:0]  dest_in;
  logic                   is_tail_in;
  logic                   send_in;
  logic                   credit_out;
  logic                   axis_out_tvalid;
  logic                   axis_out_tready;
  logic [TDATA_WIDTH-1:0] axis_out_tdata;
  logic                   axis_out_tlast;
  logic [TID_WIDTH-1:0]   axis_out_tid;
  logic [TDEST_WIDTH-1:0] axis_out_tdest;
  logic                   overflow_err;

  modport slave (
    input  data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    output credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
           axis_out_tid, axis_out_tdest, overflow_err
  );

  modport master (
    output data_in, dest_in, is_tail_in, send_in, axis_out_tready,
    input  credit_out, axis_out_tvalid, axis_out_tdata, axis_out_tlast,
           axis_out_tid, axis_out_tdest, overflow_err
  );
endinterface

// File: rtl/noc_flit_eject_axis.sv
// NoC ejection endpoint: credit-managed flit buffer feeding a flit-to-beat reassembler
// that presents packets as AXI-Stream beats.
module noc_flit_eject_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (ld)  q <= d;
    else if (clr) q <= '0;
  end
endmodule

module noc_flit_eject_axis #(
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 4,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TDEST_WIDTH + TID_WIDTH
) (
  input logic                 clk_noc,
  input logic                 rst_noc_sync,
  noc_flit_eject_axis_if.slave bus
);
  localparam int SF = SERIALIZATION_FACTOR;
  localparam int PW = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam int IW = (SF > 1) ? $clog2(SF) : 1;

  typedef struct packed {
    logic [FLIT_WIDTH-1:0] data;
    logic [DEST_WIDTH-1:0] dest;
    logic                  tail;
  } flit_t;

  flit_t                         mem [FLIT_BUFFER_DEPTH];
  flit_t                         head;
  logic [PW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count;
  logic [IW-1:0]                 idx;
  logic                          full, empty, pop, push, close;
  logic                          tvalid, tlast, credit, ovf;
  logic [TID_WIDTH-1:0]          tid;
  logic [TDEST_WIDTH-1:0]        tdest;
  logic [SF-1:0][FLIT_WIDTH-1:0] slice_q;

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(FLIT_BUFFER_DEPTH));
  assign empty = (count == '0);
  // A pending beat blocks further pops until the sink takes it.
  assign pop   = !empty && (!tvalid || bus.axis_out_tready);
  assign push  = bus.send_in && (!full || pop);
  assign close = pop && ((idx == IW'(SF - 1)) || head.tail);

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FLIT_BUFFER_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk_noc) begin
    if (push) mem[wr_ptr] <= {bus.data_in, bus.dest_in, bus.is_tail_in};
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Slice 0 overwrites on every new beat; higher slices clear so short packets pad with zero.
  for (genvar s = 0; s < SF; s++) begin : g_slice
    noc_flit_eject_slice #(.W(FLIT_WIDTH)) u_slice (
      .clk (clk_noc),
      .rst (rst_noc_sync),
      .ld  (pop && (idx == IW'(s))),
      .clr (pop && (idx == '0) && (s != 0)),
      .d   (head.data),
      .q   (slice_q[s])
    );
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      tvalid <= 1'b0;
      tlast  <= 1'b0;
      tid    <= '0;
      tdest  <= '0;
      idx    <= '0;
      credit <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      credit <= pop;
      if (bus.send_in && full && !pop) ovf <= 1'b1;
      if (pop && (idx == '0)) begin
        tid   <= head.dest[DEST_WIDTH-1:TDEST_WIDTH];
        tdest <= head.dest[TDEST_WIDTH-1:0];
      end
      if (close) begin
        tvalid <= 1'b1;
        tlast  <= head.tail;
        idx    <= '0;
      end else begin
        if (pop) idx <= idx + IW'(1);
        if (bus.axis_out_tready) tvalid <= 1'b0;
      end
    end
  end

  assign bus.credit_out      = credit;
  assign bus.axis_out_tvalid = tvalid;
  assign bus.axis_out_tdata  = slice_q;
  assign bus.axis_out_tlast  = tlast;
  assign bus.axis_out_tid    = tid;
  assign bus.axis_out_tdest  = tdest;
  assign bus.overflow_err    = ovf;
endmodule

// File: tb/tb_noc_flit_eject_axis.sv
// Bench for the NoC ejection endpoint: packet-level scoreboard for an SF=4 instance plus
// directed latency checks on an SF=1 instance.
module tb_noc_flit_eject_axis;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  noc_flit_eject_axis_if #(.TDATA_WIDTH(32), .SERIALIZATION_FACTOR(4)) f ();
  noc_flit_eject_axis_if #(.TDATA_WIDTH(32), .SERIALIZATION_FACTOR(1)) f1 ();

  noc_flit_eject_axis #(.TDATA_WIDTH(32), .SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(DEPTH)) u (
    .clk_noc(clk), .rst_noc_sync(rst), .bus(f.slave));
  noc_flit_eject_axis #(.TDATA_WIDTH(32), .SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(DEPTH)) u1 (
    .clk_noc(clk), .rst_noc_sync(rst), .bus(f1.slave));

  typedef struct {
    logic [31:0] data;
    logic [5:0]  dest;
    logic        last;
  } beat_t;

  int    checks = 0, passes = 0;
  int    cred = DEPTH, accepted = 0, credits_seen = 0;
  bit    exp_ovf = 0, pend_ovf = 0, rdy = 1;
  beat_t exp_q[$];
  logic [31:0] cur_data;
  logic [5:0]  cur_dest;
  int    cur_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Packet-level model: flits group into beats of up to 4, closed early by a tail.
  task automatic model_push(input logic [7:0] d, input logic [5:0] de, input bit t);
    beat_t b;
    if (cur_n == 0) begin cur_data = '0; cur_dest = de; end
    cur_data[cur_n*8 +: 8] = d;
    cur_n++;
    if (t || cur_n == 4) begin
      b.data = cur_data; b.dest = cur_dest; b.last = t;
      exp_q.push_back(b);
      cur_n = 0;
    end
  endtask

  task automatic cyc(input bit s, input logic [7:0] d, input logic [5:0] de, input bit t, input bit drop);
    @(posedge clk);
    if (pend_ovf) begin exp_ovf = 1; pend_ovf = 0; end
    #1;
    f.send_in = s; f.data_in = d; f.dest_in = de; f.is_tail_in = t;
    f.axis_out_tready = rdy;
    if (s) begin
      if (drop) pend_ovf = 1;
      else begin model_push(d, de, t); accepted++; cred--; end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 8'h0, 6'h0, 0, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; f.send_in = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete(); cur_n = 0; accepted = 0; credits_seen = 0;
    cred = DEPTH; exp_ovf = 0; pend_ovf = 0;
  endtask

  task automatic drain();
    rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && credits_seen == accepted) break;
      idle(1);
    end
    idle(2);
    chk("drain_beats_left", exp_q.size(), 0);
    chk("drain_credits", credits_seen, accepted);
  endtask

  // Per-cycle compare against the model.
  logic        pv, pr, pl;
  logic [31:0] pd;
  logic [1:0]  pid;
  logic [3:0]  pdst;
  always @(negedge clk) begin
    beat_t b;
    if (rst) pv = 0;
    else begin
      if (f.axis_out_tvalid && f.axis_out_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL beat_unexpected: got %0h expected none", f.axis_out_tdata);
        end else begin
          b = exp_q.pop_front();
          chk("beat", {f.axis_out_tdata, f.axis_out_tid, f.axis_out_tdest, f.axis_out_tlast},
                      {b.data, b.dest, b.last});
        end
      end
      if (pv && !pr)
        chk("hold", {f.axis_out_tvalid, f.axis_out_tdata, f.axis_out_tid, f.axis_out_tdest, f.axis_out_tlast},
                    {1'b1, pd, pid, pdst, pl});
      if (f.credit_out) begin
        credits_seen++; cred++;
        chk("credit_bound", credits_seen <= accepted, 1);
      end
      chk("overflow_err", f.overflow_err, exp_ovf);
      pv = f.axis_out_tvalid; pr = f.axis_out_tready; pd = f.axis_out_tdata;
      pid = f.axis_out_tid; pdst = f.axis_out_tdest; pl = f.axis_out_tlast;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    f.send_in = 0; f.data_in = 0; f.dest_in = 0; f.is_tail_in = 0; f.axis_out_tready = 1;
    f1.send_in = 0; f1.data_in = 0; f1.dest_in = 0; f1.is_tail_in = 0; f1.axis_out_tready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state of both instances.
    @(negedge clk);
    chk("rst_outputs", {f.axis_out_tvalid, f.axis_out_tdata, f.axis_out_tlast, f.axis_out_tid,
                        f.axis_out_tdest, f.credit_out, f.overflow_err}, 0);
    chk("rst_outputs_sf1", {f1.axis_out_tvalid, f1.axis_out_tdata, f1.axis_out_tlast, f1.credit_out,
                            f1.overflow_err}, 0);

    // SF=1 single flit latency: tvalid and credit both two cycles after send.
    @(posedge clk); #1;
    f1.send_in = 1; f1.data_in = 32'hDEADBEEF; f1.dest_in = 6'b10_0101; f1.is_tail_in = 1;
    @(negedge clk);
    chk("sf1_n_tvalid", f1.axis_out_tvalid, 0);
    @(posedge clk); #1 f1.send_in = 0;
    @(negedge clk);
    chk("sf1_n1_tvalid_credit", {f1.axis_out_tvalid, f1.credit_out}, 2'b00);
    @(negedge clk);
    chk("sf1_n2_beat", {f1.axis_out_tvalid, f1.axis_out_tdata, f1.axis_out_tid, f1.axis_out_tdest,
                        f1.axis_out_tlast, f1.credit_out}, {1'b1, 32'hDEADBEEF, 2'd2, 4'd5, 1'b1, 1'b1});
    @(negedge clk);
    chk("sf1_n3_single_pulse", {f1.axis_out_tvalid, f1.credit_out}, 2'b00);

    // SF=4 full beat from back-to-back flits: tvalid at N+5.
    cyc(1, 8'h11, 6'h13, 0, 0);
    cyc(1, 8'h22, 6'h00, 0, 0);
    cyc(1, 8'h33, 6'h00, 0, 0);
    cyc(1, 8'h44, 6'h00, 1, 0);
    @(negedge clk); chk("sf4_n3_tvalid", f.axis_out_tvalid, 0);
    idle(1);
    @(negedge clk); chk("sf4_n4_tvalid", f.axis_out_tvalid, 0);
    idle(1);
    @(negedge clk);
    chk("sf4_n5_beat", {f.axis_out_tvalid, f.axis_out_tdata, f.axis_out_tid, f.axis_out_tdest, f.axis_out_tlast},
                       {1'b1, 32'h44332211, 2'd1, 4'd3, 1'b1});
    idle(3);
    chk("sf4_credits", credits_seen, 4);

    // Randomized traffic with a credit-obeying upstream and a bursty sink.
    for (int i = 0; i < 500; i++) begin
      rdy = ($urandom_range(9) < 7);
      if (cred > 0 && $urandom_range(3) != 0)
        cyc(1, 8'($urandom), 6'($urandom), ($urandom_range(9) < 3), 0);
      else
        idle(1);
    end
    drain();

    // Back-pressure: buffer fills, credits stop, then a forced flit overflows.
    do_reset();
    rdy = 0;
    for (int i = 0, n = 0; i < 12; i++) begin
      if (cred > 0 && n < 6) begin cyc(1, 8'($urandom), 6'($urandom), 1, 0); n++; end
      else idle(1);
    end
    chk("bp_credits_stalled", credits_seen, 1);
    cyc(1, 8'hEE, 6'h3F, 1, 1);
    idle(3);
    chk("ovf_sticky", f.overflow_err, 1);
    chk("ovf_no_credit", credits_seen, 1);
    drain();
    chk("ovf_after_drain", {f.overflow_err, 4'(credits_seen)}, {1'b1, 4'd5});

    // Reset mid-beat, then short packets restart at slice 0.
    do_reset();
    @(negedge clk); chk("ovf_cleared", f.overflow_err, 0);
    cyc(1, 8'hA1, 6'h05, 0, 0);
    cyc(1, 8'hA2, 6'h05, 0, 0);
    idle(2);
    do_reset();
    @(negedge clk);
    chk("midbeat_rst_outputs", {f.axis_out_tvalid, f.axis_out_tdata, f.axis_out_tlast, f.axis_out_tid,
                                f.axis_out_tdest, f.credit_out, f.overflow_err}, 0);
    cyc(1, 8'hAA, 6'h2A, 0, 0);
    cyc(1, 8'hBB, 6'h11, 1, 0);
    idle(2);
    @(negedge clk);
    chk("short_pkt", {f.axis_out_tvalid, f.axis_out_tdata, f.axis_out_tid, f.axis_out_tdest, f.axis_out_tlast},
                     {1'b1, 32'h0000BBAA, 2'd2, 4'hA, 1'b1});
    cyc(1, 8'h01, 6'h07, 0, 0);
    cyc(1, 8'h02, 6'h00, 1, 0);
    drain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
